// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite bus-functional master: command port in, AXI4-Lite out, response port back.
// Optional per-transaction watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic chan_s;
    logic aw_done_s;
    logic w_done_s;
    logic tmo_hit_s;

    assign chan_s    = (state_q == S_WR) || (state_q == S_WB) ||
                       (state_q == S_RA) || (state_q == S_RD);
    // A write channel counts as finished once its valid has dropped or is handshaking now.
    assign aw_done_s = ~awvalid_q | awready;
    assign w_done_s  = ~wvalid_q  | wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    assign tmo_hit_s = chan_s && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog cycle counter, restarted on every accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && cmd_valid) begin
            tmo_cnt_q <= '0;
        end else if (chan_s && !tmo_hit_s) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_q <= tmo_cnt_q;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Transaction sequencer with all handshake and response outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else if (tmo_hit_s) begin
            // Deliberate protocol abort: drop every valid/ready and report an error.
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= S_RSP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RA;
                        end
                    end
                end
                S_WR: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_WB: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (bresp != 2'b00);
                        rsp_rdata_q <= '0;
                        state_q     <= S_RSP;
                    end
                end
                S_RA: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (rresp != 2'b00);
                        rsp_rdata_q <= rdata;
                        state_q     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign awaddr    = awaddr_q;
    assign araddr    = araddr_q;
    assign wdata     = wdata_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
